// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low matrix keypad one column at a time, debounces
// presses and releases, and emits one-cycle key events. Accepted key codes are shifted into a
// 16-bit entry register (newest nibble in entry[3:0]) that can drive a 4-digit display directly.
//
// Ports:
//   clk        system clock
//   rst        synchronous, active-high reset
//   row[3:0]   keypad rows, active-low, asynchronous to clk (synchronized internally)
//   entry_clr  clears entry on the next edge; wins over a coincident accept
//   col[3:0]   keypad columns, active-low, exactly one bit low
//   key_code   code of the last accepted key, 4*row_index + col_index
//   key_valid  one-cycle pulse per accepted key (and per auto-repeat when enabled)
//   key_held   high while the accepted key remains pressed
//   entry      last four key codes
//
// Optional feature: define KEYPAD_AUTOREPEAT_EN to emit repeat events while a key stays held
// (first after REPEAT_DELAY scans, then every REPEAT_RATE scans).

module keypad_scanner #(
    parameter int unsigned SCAN_DIV       = 8,
    parameter int unsigned DEBOUNCE_SCANS = 3,
    parameter int unsigned REPEAT_DELAY   = 64,
    parameter int unsigned REPEAT_RATE    = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  row,
    input  logic        entry_clr,
    output logic [3:0]  col,
    output logic [3:0]  key_code,
    output logic        key_valid,
    output logic        key_held,
    output logic [15:0] entry
);

    localparam int unsigned DIV_W = $clog2(SCAN_DIV);
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_SCANS + 1);

    // Elaboration-time guard against unusable parameter sets.
    if (SCAN_DIV < 4 || DEBOUNCE_SCANS < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1)
    begin : g_param_check
        $error("keypad_scanner: illegal parameter set");
    end

    typedef enum logic [1:0] {
        StScan,
        StDebounce,
        StHeld
    } state_e;

    state_e             state_q, state_d;
    logic [3:0]         row_meta_q, row_s;
    logic [DIV_W-1:0]   div_q;
    logic               tick;
    logic [1:0]         c_q, c_d;
    logic [1:0]         r_q, r_d;
    logic [CNT_W-1:0]   deb_q, deb_d;
    logic [CNT_W-1:0]   rel_q, rel_d;
    logic [1:0]         low_row;
    logic               accept;
    logic               release_done;
    logic               rpt_pulse;
    logic [3:0]         key_code_d;
    logic               key_valid_d;
    logic               key_held_d;
    logic [15:0]        entry_d;

    assign tick = (div_q == DIV_W'(SCAN_DIV - 1));
    assign col  = ~(4'b0001 << c_q);

    // Lowest-index active row wins when several rows are low.
    always_comb begin
        low_row = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!row_s[i]) low_row = 2'(i);
        end
    end

    always_comb begin
        state_d      = state_q;
        c_d          = c_q;
        r_d          = r_q;
        deb_d        = deb_q;
        rel_d        = rel_q;
        accept       = 1'b0;
        release_done = 1'b0;
        unique case (state_q)
            StScan: begin
                if (tick) begin
                    if (row_s == 4'b1111) begin
                        c_d = c_q + 2'd1;
                    end else begin
                        r_d = low_row;
                        if (DEBOUNCE_SCANS == 1) begin
                            accept  = 1'b1;
                            deb_d   = '0;
                            rel_d   = '0;
                            state_d = StHeld;
                        end else begin
                            deb_d   = CNT_W'(1);
                            state_d = StDebounce;
                        end
                    end
                end
            end
            StDebounce: begin
                if (tick) begin
                    if (!row_s[r_q]) begin
                        if ((deb_q + CNT_W'(1)) == CNT_W'(DEBOUNCE_SCANS)) begin
                            accept  = 1'b1;
                            deb_d   = '0;
                            rel_d   = '0;
                            state_d = StHeld;
                        end else begin
                            deb_d = deb_q + CNT_W'(1);
                        end
                    end else begin
                        // Bounce: abandon this key and keep scanning.
                        deb_d   = '0;
                        c_d     = c_q + 2'd1;
                        state_d = StScan;
                    end
                end
            end
            StHeld: begin
                if (tick) begin
                    if (row_s[r_q]) begin
                        if ((rel_q + CNT_W'(1)) == CNT_W'(DEBOUNCE_SCANS)) begin
                            release_done = 1'b1;
                            rel_d        = '0;
                            c_d          = c_q + 2'd1;
                            state_d      = StScan;
                        end else begin
                            rel_d = rel_q + CNT_W'(1);
                        end
                    end else begin
                        rel_d = '0;
                    end
                end
            end
            default: begin
                state_d = StScan;
            end
        endcase
    end

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned RPT_W   = $clog2(RPT_MAX + 1);

    logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
    logic             rpt_phase_q, rpt_phase_d;  // 0: waiting for first repeat, 1: repeating
    logic [RPT_W-1:0] rpt_target;

    assign rpt_target = rpt_phase_q ? RPT_W'(REPEAT_RATE) : RPT_W'(REPEAT_DELAY);

    always_comb begin
        rpt_cnt_d   = rpt_cnt_q;
        rpt_phase_d = rpt_phase_q;
        rpt_pulse   = 1'b0;
        if (state_q != StHeld || state_d != StHeld) begin
            // Covers entry into HELD and leaving it.
            rpt_cnt_d   = '0;
            rpt_phase_d = 1'b0;
        end else if (tick) begin
            if (row_s[r_q]) begin
                rpt_cnt_d   = '0;
                rpt_phase_d = 1'b0;
            end else if ((rpt_cnt_q + RPT_W'(1)) == rpt_target) begin
                rpt_pulse   = 1'b1;
                rpt_cnt_d   = '0;
                rpt_phase_d = 1'b1;
            end else begin
                rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rpt_cnt_q   <= '0;
            rpt_phase_q <= 1'b0;
        end else begin
            rpt_cnt_q   <= rpt_cnt_d;
            rpt_phase_q <= rpt_phase_d;
        end
    end
`else
    assign rpt_pulse = 1'b0;
`endif

    always_comb begin
        key_code_d  = accept ? {r_d, c_q} : key_code;
        key_valid_d = accept | rpt_pulse;
        key_held_d  = key_held;
        if (accept) begin
            key_held_d = 1'b1;
        end else if (release_done) begin
            key_held_d = 1'b0;
        end
        entry_d = entry;
        if (entry_clr) begin
            entry_d = 16'h0000;
        end else if (key_valid_d) begin
            entry_d = {entry[11:0], key_code_d};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_meta_q <= 4'b1111;
            row_s      <= 4'b1111;
            div_q      <= '0;
            state_q    <= StScan;
            c_q        <= 2'd0;
            r_q        <= 2'd0;
            deb_q      <= '0;
            rel_q      <= '0;
            key_code   <= 4'h0;
            key_valid  <= 1'b0;
            key_held   <= 1'b0;
            entry      <= 16'h0000;
        end else begin
            row_meta_q <= row;
            row_s      <= row_meta_q;
            div_q      <= tick ? '0 : div_q + DIV_W'(1);
            state_q    <= state_d;
            c_q        <= c_d;
            r_q        <= r_d;
            deb_q      <= deb_d;
            rel_q      <= rel_d;
            key_code   <= key_code_d;
            key_valid  <= key_valid_d;
            key_held   <= key_held_d;
            entry      <= entry_d;
        end
    end

endmodule
